icache_tag_ctrl: RTL and testbench
==================================

// Module: icache_tag_ctrl
// PURPOSE
//  Initiator side of the I-cache tag SRAM port (csb0/web0/addr0/din0/dout0, 16 x 23b).
//  Accepts lookups and fills from the I-cache FSM, drives the SRAM, and returns hit/miss one cycle later.
//  Holds the per-set valid bits in resettable flops, since SRAM contents are never reset.
//  Sits between the fetch-side cache FSM and the instr_cache tag SRAM macro.
// PARAMETERS
//  ADDR_W    32  byte address width
//  OFFSET_W  5   line offset bits (32B lines)
//  INDEX_W   4   set index bits (16 sets = SRAM depth)
//  TAG_W     23  ADDR_W-INDEX_W-OFFSET_W; equals SRAM word width
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        synchronous active-low reset
//  lkp_valid    in   1        lookup request
//  lkp_ready    out  1        lookup accepted when valid&ready
//  lkp_addr     in   ADDR_W   lookup byte address
//  rsp_valid    out  1        lookup result available
//  rsp_ready    in   1        consumer takes result
//  rsp_hit      out  1        valid && stored tag == request tag
//  rsp_index    out  INDEX_W  set index of the result
//  rsp_tag      out  TAG_W    tag read from SRAM
//  fill_valid   in   1        tag write request (line refill)
//  fill_ready   out  1        fill accepted when valid&ready
//  fill_addr    in   ADDR_W   refilled line address
//  inv_all      in   1        one-cycle pulse: clear all valid bits
//  sram_csb0    out  1        SRAM chip select, active low
//  sram_web0    out  1        SRAM write enable, active low
//  sram_addr0   out  INDEX_W  SRAM address
//  sram_din0    out  TAG_W    SRAM write data
//  sram_dout0   in   TAG_W    SRAM read data (valid the cycle after a read is issued)
// BEHAVIOUR
//  - Clock clk; reset rst_n synchronous, active low. Reset: valid_q=0, rsp_valid=0, sram_csb0=1, sram_web0=1,
//    sram_addr0=0, sram_din0=0, state=PRIME. A reset mid-operation drops any pending response.
//  - States: PRIME -> RUN. PRIME lasts 1 cycle and issues a dummy read (csb0=0, web0=1, addr0=0)
//    to give the SRAM port registers known values. lkp_ready=fill_ready=0 in PRIME.
//  - free = !rsp_valid || rsp_ready (response slot empty or draining this cycle).
//  - Priority in RUN: inv_all > fill > lookup.
//    fill_ready = free && !inv_all;  lkp_ready = free && !inv_all && !fill_valid.
//  - Lookup accept (cycle N): csb0=0, web0=1, addr0=lkp_addr index; latch req tag and valid_q[idx].
//    Cycle N+1: rsp_valid=1, rsp_tag=sram_dout0, rsp_hit=vbit_q && (sram_dout0==req tag). Throughput 1/cycle.
//  - Response stall: while rsp_valid && !rsp_ready, csb0 stays 1 so the SRAM address register and
//    dout0 hold; rsp_* stable until taken.
//  - Fill accept: csb0=0, web0=0, addr0=index, din0=tag of fill_addr; valid_q[index] set on the same edge.
//    Fill on an accept edge where rsp_ready drains the slot is legal; no response is produced for a fill.
//  - After a write, csb0 idles high; the SRAM repeats the latched write each cycle (idempotent, allowed).
//  - inv_all: valid_q cleared at the edge; a latched vbit_q of a pending response is also cleared, so a
//    response sampled after inv_all reports miss. Fill and lookup in the same cycle are not accepted.
//  - A read issued the cycle after a write to the same index returns the newly written tag (no bypass).
//  - Idle (no accept): csb0=1, web0=1; addr0/din0 hold last value.
// STRUCTURE
//  - icache_pkg: OFFSET_W, INDEX_W, TAG_W constants; index/tag extraction functions from ADDR_W address.
//  - Sub-module icache_valid_array: 2^INDEX_W valid flops with set(idx) and clear_all, sync active-low reset.
//  - Remainder (2-state FSM, response register, SRAM drive mux) lives in icache_tag_ctrl.
// TESTING  (bench includes the real tag SRAM model)
//  1 Reset then lookup 0x0000_1040 -> PRIME cycle seen (csb0=0, web0=1, addr0=0); rsp_hit=0, rsp_index=2.
//  2 Fill 0x8000_0060, then lookup 0x8000_0064 the next cycle -> rsp_hit=1, rsp_tag=0x400000, rsp_index=3.
//  3 Lookups to 16 consecutive lines with rsp_ready=1 -> 16 responses on 16 consecutive cycles, no bubbles.
//  4 Response held with rsp_ready=0 for 5 cycles while lkp_valid=1 -> csb0=1, rsp_* stable, lkp_ready=0.
//  5 fill_valid, lkp_valid and inv_all together -> none accepted, all valid bits 0; next cycle fill accepted.
//  6 Fill index 5, lookup index 5 pending, inv_all pulse, then rsp_ready -> rsp_hit=0; rst_n low mid-stream -> rsp_valid=0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared geometry and address-slicing helpers for the I-cache tag path.
// 32-bit byte address, 32B lines, 16 sets, 23-bit tags.
package icache_pkg;

   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = 5;
   localparam int INDEX_W  = 4;
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int NUM_SETS = 1 << INDEX_W;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [INDEX_W-1:0] index_t;
   typedef logic [TAG_W-1:0]   tag_t;

   typedef enum logic {
      ST_PRIME,
      ST_RUN
   } state_e;

   function automatic index_t addr_index(input addr_t addr);
      return addr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic tag_t addr_tag(input addr_t addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

endpackage

// File: rtl/icache_valid_array.sv
// Per-set valid bits for the I-cache tag store.
// A single set per cycle, or a whole-array clear that takes priority.
module icache_valid_array
   import icache_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                set_en,
   input  index_t              set_idx,
   input  logic                clear_all,
   output logic [NUM_SETS-1:0] valid
);

   // NOTE: valid bits live in resettable flops; the tag SRAM itself powers up with garbage and is never reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (clear_all) begin
         valid <= '0;
      end else if (set_en) begin
         valid[set_idx] <= 1'b1;
      end
   end

endmodule

// File: rtl/icache_tag_ctrl.sv
// Initiator for the I-cache tag SRAM: arbitrates invalidate/fill/lookup,
// drives the single-port macro, and returns hit/miss one cycle after a lookup.
module icache_tag_ctrl
   import icache_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               lkp_valid,
   output logic               lkp_ready,
   input  logic [ADDR_W-1:0]  lkp_addr,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_hit,
   output logic [INDEX_W-1:0] rsp_index,
   output logic [TAG_W-1:0]   rsp_tag,
   input  logic               fill_valid,
   output logic               fill_ready,
   input  logic [ADDR_W-1:0]  fill_addr,
   input  logic               inv_all,
   output logic               sram_csb0,
   output logic               sram_web0,
   output logic [INDEX_W-1:0] sram_addr0,
   output logic [TAG_W-1:0]   sram_din0,
   input  logic [TAG_W-1:0]   sram_dout0
);

   state_e              state_q, state_d;
   logic                rsp_valid_q;
   logic                vbit_q;
   index_t              rsp_index_q;
   tag_t                req_tag_q;
   index_t              addr_q;
   tag_t                din_q;
   logic [NUM_SETS-1:0] valid_bits;
   logic                free;
   logic                fill_acc;
   logic                lkp_acc;
   index_t              lkp_idx;
   index_t              fill_idx;
   tag_t                lkp_tag;
   tag_t                fill_tag;

   assign lkp_idx  = addr_index(lkp_addr);
   assign lkp_tag  = addr_tag(lkp_addr);
   assign fill_idx = addr_index(fill_addr);
   assign fill_tag = addr_tag(fill_addr);

   assign free     = !rsp_valid_q || rsp_ready;
   assign fill_acc = fill_valid && fill_ready;
   assign lkp_acc  = lkp_valid && lkp_ready;

   // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_PRIME;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PRIME: state_d = ST_RUN;
         ST_RUN:   state_d = ST_RUN;
         default:  state_d = ST_PRIME;
      endcase
   end

   // NOTE: every output gets a default before the case so no path leaves a latch behind.
   always_comb begin
      lkp_ready  = 1'b0;
      fill_ready = 1'b0;
      sram_csb0  = 1'b1;
      sram_web0  = 1'b1;
      sram_addr0 = addr_q;
      sram_din0  = din_q;
      if (rst_n) begin
         case (state_q)
            ST_PRIME: begin
               // Dummy read gives the macro's input registers a defined value.
               sram_csb0  = 1'b0;
               sram_addr0 = '0;
            end
            ST_RUN: begin
               fill_ready = free && !inv_all;
               lkp_ready  = free && !inv_all && !fill_valid;
               if (fill_valid && free && !inv_all) begin
                  sram_csb0  = 1'b0;
                  sram_web0  = 1'b0;
                  sram_addr0 = fill_idx;
                  sram_din0  = fill_tag;
               end else if (lkp_valid && free && !inv_all) begin
                  sram_csb0  = 1'b0;
                  sram_addr0 = lkp_idx;
               end
            end
            default: begin
               sram_csb0 = 1'b1;
            end
         endcase
      end
   end

   // Address/data pins hold their last driven value while the port idles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= '0;
         din_q  <= '0;
      end else begin
         addr_q <= sram_addr0;
         din_q  <= sram_din0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         vbit_q      <= 1'b0;
         rsp_index_q <= '0;
         req_tag_q   <= '0;
      end else if (lkp_acc) begin
         rsp_valid_q <= 1'b1;
         vbit_q      <= valid_bits[lkp_idx];
         rsp_index_q <= lkp_idx;
         req_tag_q   <= lkp_tag;
      end else begin
         if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
         // A pending result must not report a hit on a line just invalidated.
         if (inv_all) begin
            vbit_q <= 1'b0;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_index = rsp_index_q;
   assign rsp_tag   = sram_dout0;
   assign rsp_hit   = vbit_q && (sram_dout0 == req_tag_q);

   icache_valid_array u_valid_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en    (fill_acc),
      .set_idx   (fill_idx),
      .clear_all (inv_all),
      .valid     (valid_bits)
   );

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Directed bench for icache_tag_ctrl with a behavioural single-port tag SRAM attached.
module tb_icache_tag_ctrl;
   import icache_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               lkp_valid;
   logic               lkp_ready;
   logic [ADDR_W-1:0]  lkp_addr;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_hit;
   logic [INDEX_W-1:0] rsp_index;
   logic [TAG_W-1:0]   rsp_tag;
   logic               fill_valid;
   logic               fill_ready;
   logic [ADDR_W-1:0]  fill_addr;
   logic               inv_all;
   logic               sram_csb0;
   logic               sram_web0;
   logic [INDEX_W-1:0] sram_addr0;
   logic [TAG_W-1:0]   sram_din0;
   logic [TAG_W-1:0]   sram_dout0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   icache_tag_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lkp_valid  (lkp_valid),
      .lkp_ready  (lkp_ready),
      .lkp_addr   (lkp_addr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_hit    (rsp_hit),
      .rsp_index  (rsp_index),
      .rsp_tag    (rsp_tag),
      .fill_valid (fill_valid),
      .fill_ready (fill_ready),
      .fill_addr  (fill_addr),
      .inv_all    (inv_all),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_dout0 (sram_dout0)
   );

   // Tag SRAM macro: inputs sampled at the edge, read data registered, dout holds while deselected.
   logic [TAG_W-1:0] mem [NUM_SETS] = '{default: '0};
   logic [TAG_W-1:0] dout_q = '0;

   always @(posedge clk) begin
      if (!sram_csb0) begin
         if (!sram_web0) mem[sram_addr0] <= sram_din0;
         else            dout_q <= mem[sram_addr0];
      end
   end
   assign sram_dout0 = dout_q;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one lookup, checks acceptance, then checks the response the next cycle.
   task automatic lookup(input string name, input logic [31:0] addr, input logic exp_hit,
                         input logic [31:0] exp_tag, input logic [31:0] exp_idx);
      lkp_valid = 1'b1;
      lkp_addr  = addr;
      #1;
      check({name, "_lkp_ready"}, 32'(lkp_ready), 1);
      check({name, "_csb"}, 32'(sram_csb0), 0);
      check({name, "_sram_addr"}, 32'(sram_addr0), exp_idx);
      step();
      lkp_valid = 1'b0;
      #1;
      check({name, "_rsp_valid"}, 32'(rsp_valid), 1);
      check({name, "_rsp_hit"}, 32'(rsp_hit), 32'(exp_hit));
      check({name, "_rsp_tag"}, 32'(rsp_tag), exp_tag);
      check({name, "_rsp_index"}, 32'(rsp_index), exp_idx);
   endtask

   initial begin
      rst_n      = 1'b0;
      lkp_valid  = 1'b0;
      lkp_addr   = '0;
      rsp_ready  = 1'b1;
      fill_valid = 1'b0;
      fill_addr  = '0;
      inv_all    = 1'b0;
      repeat (3) step();

      check("rst_csb", 32'(sram_csb0), 1);
      check("rst_web", 32'(sram_web0), 1);
      check("rst_addr", 32'(sram_addr0), 0);
      check("rst_din", 32'(sram_din0), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_lkp_ready", 32'(lkp_ready), 0);

      // PRIME cycle: dummy read of address 0, no requests accepted.
      rst_n = 1'b1;
      #1;
      check("prime_csb", 32'(sram_csb0), 0);
      check("prime_web", 32'(sram_web0), 1);
      check("prime_addr", 32'(sram_addr0), 0);
      check("prime_lkp_ready", 32'(lkp_ready), 0);
      check("prime_fill_ready", 32'(fill_ready), 0);
      step();

      // Cold lookups miss: set 2 (tag 8) and set 4 (tag 0, matching the SRAM's zero contents).
      lookup("t1", 32'h0000_1040, 1'b0, 0, 2);
      lookup("t1b", 32'h0000_0080, 1'b0, 0, 4);

      // Fill in the cycle the previous response drains, then hit it the next cycle.
      fill_valid = 1'b1;
      fill_addr  = 32'h8000_0060;
      #1;
      check("t2_fill_ready", 32'(fill_ready), 1);
      check("t2_fill_web", 32'(sram_web0), 0);
      check("t2_fill_addr", 32'(sram_addr0), 3);
      check("t2_fill_din", 32'(sram_din0), 32'h40_0000);
      step();
      fill_valid = 1'b0;
      lookup("t2", 32'h8000_0064, 1'b1, 32'h40_0000, 3);

      // Back-to-back lookups across all 16 sets: one response every cycle.
      for (int i = 0; i <= NUM_SETS; i++) begin
         lkp_valid = (i < NUM_SETS);
         lkp_addr  = 32'h8000_0000 + 32'(i) * 32;
         #1;
         if (i < NUM_SETS) check($sformatf("t3_lkp_ready_%0d", i), 32'(lkp_ready), 1);
         if (i > 0) begin
            check($sformatf("t3_rsp_valid_%0d", i - 1), 32'(rsp_valid), 1);
            check($sformatf("t3_rsp_index_%0d", i - 1), 32'(rsp_index), 32'(i - 1));
            check($sformatf("t3_rsp_hit_%0d", i - 1), 32'(rsp_hit), (i - 1 == 3) ? 1 : 0);
            check($sformatf("t3_rsp_tag_%0d", i - 1), 32'(rsp_tag), (i - 1 == 3) ? 32'h40_0000 : 0);
         end
         step();
      end
      lkp_valid = 1'b0;
      #1;
      check("t3_drained", 32'(rsp_valid), 0);

      // Stalled response: slot held, port deselected, new lookup refused.
      rsp_ready = 1'b0;
      lookup("t4", 32'h8000_0060, 1'b1, 32'h40_0000, 3);
      lkp_valid = 1'b1;
      lkp_addr  = 32'h0000_0020;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("t4_hold_csb_%0d", c), 32'(sram_csb0), 1);
         check($sformatf("t4_hold_lkp_ready_%0d", c), 32'(lkp_ready), 0);
         check($sformatf("t4_hold_rsp_valid_%0d", c), 32'(rsp_valid), 1);
         check($sformatf("t4_hold_rsp_hit_%0d", c), 32'(rsp_hit), 1);
         check($sformatf("t4_hold_rsp_tag_%0d", c), 32'(rsp_tag), 32'h40_0000);
         check($sformatf("t4_hold_rsp_index_%0d", c), 32'(rsp_index), 3);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      check("t4_release_lkp_ready", 32'(lkp_ready), 1);
      step();
      lkp_valid = 1'b0;
      #1;
      check("t4_next_rsp_index", 32'(rsp_index), 1);
      check("t4_next_rsp_hit", 32'(rsp_hit), 0);
      step();

      // inv_all with fill and lookup: nothing accepted, then the fill goes through.
      fill_valid = 1'b1;
      fill_addr  = 32'h0000_00E0;
      lkp_valid  = 1'b1;
      lkp_addr   = 32'h8000_0060;
      inv_all    = 1'b1;
      #1;
      check("t5_fill_ready", 32'(fill_ready), 0);
      check("t5_lkp_ready", 32'(lkp_ready), 0);
      check("t5_csb", 32'(sram_csb0), 1);
      step();
      inv_all   = 1'b0;
      lkp_valid = 1'b0;
      #1;
      check("t5_fill_ready_next", 32'(fill_ready), 1);
      check("t5_fill_csb_next", 32'(sram_csb0), 0);
      check("t5_fill_web_next", 32'(sram_web0), 0);
      check("t5_fill_addr_next", 32'(sram_addr0), 7);
      step();
      fill_valid = 1'b0;
      lookup("t5_cleared", 32'h8000_0060, 1'b0, 32'h40_0000, 3);
      lookup("t5_refilled", 32'h0000_00E0, 1'b1, 0, 7);

      // Fill set 5, leave its hit pending, invalidate, then take it: reported as miss.
      fill_valid = 1'b1;
      fill_addr  = 32'h1234_50A0;
      #1;
      check("t6_fill_ready", 32'(fill_ready), 1);
      step();
      fill_valid = 1'b0;
      rsp_ready  = 1'b0;
      lookup("t6_pend", 32'h1234_50A0, 1'b1, 32'h09_1A28, 5);
      inv_all = 1'b1;
      step();
      inv_all = 1'b0;
      #1;
      check("t6_inv_rsp_valid", 32'(rsp_valid), 1);
      check("t6_inv_rsp_hit", 32'(rsp_hit), 0);
      check("t6_inv_rsp_tag", 32'(rsp_tag), 32'h09_1A28);
      rsp_ready = 1'b1;
      step();

      // Reset while a response is pending drops it.
      lkp_valid = 1'b1;
      lkp_addr  = 32'h0000_0040;
      step();
      lkp_valid = 1'b0;
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      #1;
      check("t6_rst_csb", 32'(sram_csb0), 1);
      step();
      check("t6_rst_rsp_valid", 32'(rsp_valid), 0);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      #1;
      check("t6_prime_csb", 32'(sram_csb0), 0);
      step();
      lookup("t6_after_rst", 32'h1234_50A0, 1'b0, 32'h09_1A28, 5);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
